if_id_stage: RTL and testbench

- IF/ID pipeline register between the instruction ROM and the decode/execute logic.
- Captures the fetched 9-bit instruction and its PC, and supports stall and flush.
- Pre-decodes the branch class into one-hot BranchEZ/BranchNZ/BranchAlways. These feed the fetch stage, together with the sticky Done flag that stops PC increment.
- Keeps saturating cycle and retired-instruction counters for benches.

---
 rtl/cpu_pkg.sv | 41 ++++
 rtl/sat_counter.sv | 32 +++
 rtl/if_id_stage.sv | 108 ++++++++++
 tb/tb_if_id_stage.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared widths, opcode map and branch pre-decode for the IF/ID slice.
package cpu_pkg;

  localparam int PC_W   = 10;
  localparam int INST_W = 9;
  localparam int TGT_W  = 8;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_BEZ  = 4'hC,
    OP_BNZ  = 4'hD,
    OP_BRA  = 4'hE,
    OP_HALT = 4'hF
  } opcode_e;

  localparam logic [INST_W-1:0] NOP_INST = 9'h000;

  // One-hot branch class; all-zero for anything that is not a branch.
  typedef struct packed {
    logic ez;
    logic nz;
    logic bra;
  } branch_t;

  function automatic branch_t decode_branch(input logic [INST_W-1:0] inst);
    branch_t br;
    br = '0;
    case (inst[INST_W-1 -: 4])
      OP_BEZ:  br.ez  = 1'b1;
      OP_BNZ:  br.nz  = 1'b1;
      OP_BRA:  br.bra = 1'b1;
      default: br     = '0;
    endcase
    return br;
  endfunction

  function automatic logic is_halt(input logic [INST_W-1:0] inst);
    return inst[INST_W-1 -: 4] == OP_HALT;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         En,
  output logic [W-1:0] Count
);

  logic [W-1:0] count_q, count_d;

  // Next count: advance only when enabled and not yet saturated.
  always_comb begin
    count_d = count_q;
    if (En && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign Count = count_q;

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with branch pre-decode, sticky halt and bench counters.
// Update priority on each edge: Reset > Flush > Stall > Done > load/bubble.
module if_id_stage
  import cpu_pkg::*;
#(
  parameter int T = PC_W,
  parameter int I = INST_W,
  parameter int C = 16
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic [T-1:0] FetchPC,
  input  logic [I-1:0] FetchInst,
  input  logic         FetchValid,
  input  logic         Stall,
  input  logic         Flush,
  output logic [T-1:0] IdPC,
  output logic [I-1:0] IdInst,
  output logic         IdValid,
  output logic         BranchEZ,
  output logic         BranchNZ,
  output logic         BranchAlways,
  output logic [TGT_W-1:0] Target,
  output logic         Done,
  output logic [C-1:0] CycleCount,
  output logic [C-1:0] InstCount
);

  logic [T-1:0] pc_q, pc_d;
  logic [I-1:0] inst_q, inst_d;
  logic         valid_q, valid_d;
  branch_t      br_q, br_d;
  logic         done_q, done_d;
  logic         load_valid;

  // Next-state selection for the ID registers and the halt flag.
  always_comb begin
    pc_d       = pc_q;
    inst_d     = inst_q;
    valid_d    = valid_q;
    br_d       = br_q;
    done_d     = done_q;
    load_valid = 1'b0;
    if (Flush) begin
      inst_d  = I'(NOP_INST);
      valid_d = 1'b0;
      br_d    = '0;
    end else if (Stall) begin
      // hold everything
    end else if (done_q) begin
      // halted: keep the HALT in ID but never let fetch redirect
      br_d = '0;
    end else if (FetchValid) begin
      pc_d       = FetchPC;
      inst_d     = FetchInst;
      valid_d    = 1'b1;
      br_d       = decode_branch(FetchInst);
      done_d     = is_halt(FetchInst);
      load_valid = 1'b1;
    end else begin
      // no instruction from fetch: insert a bubble, PC holds
      inst_d  = I'(NOP_INST);
      valid_d = 1'b0;
      br_d    = '0;
    end
  end

  // ID-stage registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc_q    <= '0;
      inst_q  <= I'(NOP_INST);
      valid_q <= 1'b0;
      br_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      valid_q <= valid_d;
      br_q    <= br_d;
      done_q  <= done_d;
    end
  end

  sat_counter #(.W(C)) u_cycle_cnt (
    .Clk   (Clk),
    .Reset (Reset),
    .En    (~done_q),
    .Count (CycleCount)
  );

  sat_counter #(.W(C)) u_inst_cnt (
    .Clk   (Clk),
    .Reset (Reset),
    .En    (load_valid),
    .Count (InstCount)
  );

  assign IdPC         = pc_q;
  assign IdInst       = inst_q;
  assign IdValid      = valid_q;
  assign BranchEZ     = br_q.ez;
  assign BranchNZ     = br_q.nz;
  assign BranchAlways = br_q.bra;
  assign Target       = {{(TGT_W-5){1'b0}}, inst_q[4:0]};
  assign Done         = done_q;

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage: directed vector table, saturation
// sequence on a narrow-counter instance, and randomized traffic vs a model.
module tb_if_id_stage;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic [9:0] FetchPC = '0;
  logic [8:0] FetchInst = '0;
  logic       FetchValid = 1'b0;
  logic       Stall = 1'b0;
  logic       Flush = 1'b0;

  logic [9:0]  IdPC;
  logic [8:0]  IdInst;
  logic        IdValid, BranchEZ, BranchNZ, BranchAlways, Done;
  logic [7:0]  Target;
  logic [15:0] CycleCount, InstCount;

  logic [9:0]  sIdPC;
  logic [8:0]  sIdInst;
  logic        sIdValid, sBranchEZ, sBranchNZ, sBranchAlways, sDone;
  logic [7:0]  sTarget;
  logic [3:0]  sCycleCount, sInstCount;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 Clk = ~Clk;

  if_id_stage dut (
    .Clk(Clk), .Reset(Reset), .FetchPC(FetchPC), .FetchInst(FetchInst),
    .FetchValid(FetchValid), .Stall(Stall), .Flush(Flush),
    .IdPC(IdPC), .IdInst(IdInst), .IdValid(IdValid),
    .BranchEZ(BranchEZ), .BranchNZ(BranchNZ), .BranchAlways(BranchAlways),
    .Target(Target), .Done(Done), .CycleCount(CycleCount), .InstCount(InstCount)
  );

  if_id_stage #(.C(4)) dut_small (
    .Clk(Clk), .Reset(Reset), .FetchPC(FetchPC), .FetchInst(FetchInst),
    .FetchValid(FetchValid), .Stall(Stall), .Flush(Flush),
    .IdPC(sIdPC), .IdInst(sIdInst), .IdValid(sIdValid),
    .BranchEZ(sBranchEZ), .BranchNZ(sBranchNZ), .BranchAlways(sBranchAlways),
    .Target(sTarget), .Done(sDone), .CycleCount(sCycleCount), .InstCount(sInstCount)
  );

  // Reference model: architectural view of the ID slot plus unbounded event counts.
  logic [9:0] m_pc;
  logic [8:0] m_inst;
  bit         m_valid, m_done;
  int         m_cyc, m_icnt;

  function automatic logic [2:0] exp_branch();
    if (!m_valid || m_done) return 3'b000;
    case (m_inst[8:5])
      4'hC:    return 3'b100;
      4'hD:    return 3'b010;
      4'hE:    return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_update(input bit rst, input bit fl, input bit st, input bit fv,
                              input logic [9:0] pc, input logic [8:0] inst);
    if (rst) begin
      m_pc = '0; m_inst = '0; m_valid = 0; m_done = 0; m_cyc = 0; m_icnt = 0;
    end else begin
      if (!m_done) m_cyc++;
      if (fl || (!st && !m_done && !fv)) begin
        m_inst = '0;
        m_valid = 0;
      end else if (!st && !m_done) begin
        m_pc = pc;
        m_inst = inst;
        m_valid = 1;
        m_icnt++;
        if (inst[8:5] == 4'hF) m_done = 1;
      end
    end
  endtask

  task automatic check_model();
    chk("pc", IdPC, m_pc);
    chk("inst", IdInst, m_inst);
    chk("valid", IdValid, m_valid);
    chk("branch", {BranchEZ, BranchNZ, BranchAlways}, exp_branch());
    chk("target", Target, {3'b000, m_inst[4:0]});
    chk("done", Done, m_done);
    chk("cycle_cnt", CycleCount, sat(m_cyc, 65535));
    chk("inst_cnt", InstCount, sat(m_icnt, 65535));
    chk("small_cycle_cnt", sCycleCount, sat(m_cyc, 15));
    chk("small_inst_cnt", sInstCount, sat(m_icnt, 15));
  endtask

  // Drive one edge's inputs, advance the model, sample #1 after the edge.
  task automatic step(input bit rst, input bit fl, input bit st, input bit fv,
                      input logic [9:0] pc, input logic [8:0] inst);
    Reset = rst; Flush = fl; Stall = st; FetchValid = fv;
    FetchPC = pc; FetchInst = inst;
    model_update(rst, fl, st, fv, pc, inst);
    @(posedge Clk);
    #1;
    check_model();
  endtask

  typedef struct {
    bit rst, fl, st, fv;
    logic [9:0] pc;
    logic [8:0] inst;
    logic [9:0] e_pc;
    logic [8:0] e_inst;
    bit e_valid;
    logic [2:0] e_br;
    logic [7:0] e_tgt;
    bit e_done;
    int e_ic, e_cc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit rst, bit fl, bit st, bit fv, logic [9:0] pc, logic [8:0] inst,
                              logic [9:0] e_pc, logic [8:0] e_inst, bit e_valid,
                              logic [2:0] e_br, logic [7:0] e_tgt, bit e_done, int e_ic, int e_cc);
    vec_t v;
    v.rst = rst; v.fl = fl; v.st = st; v.fv = fv; v.pc = pc; v.inst = inst;
    v.e_pc = e_pc; v.e_inst = e_inst; v.e_valid = e_valid; v.e_br = e_br;
    v.e_tgt = e_tgt; v.e_done = e_done; v.e_ic = e_ic; v.e_cc = e_cc;
    return v;
  endfunction

  initial begin
    //          rst fl st fv pc     inst      e_pc   e_inst   v  br      tgt     d ic cc
    vecs.push_back(mk(1, 0, 0, 0, 10'd0, 9'h000, 10'd0, 9'h000, 0, 3'b000, 8'h00, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 10'd0, 9'h021, 10'd0, 9'h021, 1, 3'b000, 8'h01, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 1, 10'd1, 9'h185, 10'd1, 9'h185, 1, 3'b100, 8'h05, 0, 2, 2));
    vecs.push_back(mk(0, 1, 0, 1, 10'd2, 9'h021, 10'd1, 9'h000, 0, 3'b000, 8'h00, 0, 2, 3));
    vecs.push_back(mk(0, 0, 0, 1, 10'd3, 9'h1C3, 10'd3, 9'h1C3, 1, 3'b001, 8'h03, 0, 3, 4));
    vecs.push_back(mk(0, 0, 1, 1, 10'd4, 9'h021, 10'd3, 9'h1C3, 1, 3'b001, 8'h03, 0, 3, 5));
    vecs.push_back(mk(0, 0, 1, 1, 10'd4, 9'h021, 10'd3, 9'h1C3, 1, 3'b001, 8'h03, 0, 3, 6));
    vecs.push_back(mk(0, 0, 1, 1, 10'd4, 9'h021, 10'd3, 9'h1C3, 1, 3'b001, 8'h03, 0, 3, 7));
    vecs.push_back(mk(0, 1, 1, 1, 10'd4, 9'h021, 10'd3, 9'h000, 0, 3'b000, 8'h00, 0, 3, 8));
    vecs.push_back(mk(0, 0, 0, 0, 10'd4, 9'h021, 10'd3, 9'h000, 0, 3'b000, 8'h00, 0, 3, 9));
    vecs.push_back(mk(0, 0, 0, 1, 10'd4, 9'h1A2, 10'd4, 9'h1A2, 1, 3'b010, 8'h02, 0, 4, 10));
    vecs.push_back(mk(0, 0, 1, 1, 10'd7, 9'h1E0, 10'd4, 9'h1A2, 1, 3'b010, 8'h02, 0, 4, 11));
    vecs.push_back(mk(0, 0, 0, 1, 10'd7, 9'h1E0, 10'd7, 9'h1E0, 1, 3'b000, 8'h00, 1, 5, 12));
    vecs.push_back(mk(0, 0, 0, 1, 10'd8, 9'h021, 10'd7, 9'h1E0, 1, 3'b000, 8'h00, 1, 5, 12));
    vecs.push_back(mk(0, 0, 0, 1, 10'd9, 9'h1C3, 10'd7, 9'h1E0, 1, 3'b000, 8'h00, 1, 5, 12));
    vecs.push_back(mk(0, 1, 0, 1, 10'd9, 9'h021, 10'd7, 9'h000, 0, 3'b000, 8'h00, 1, 5, 12));
    vecs.push_back(mk(1, 0, 0, 1, 10'd9, 9'h021, 10'd0, 9'h000, 0, 3'b000, 8'h00, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 1, 10'd5, 9'h1E0, 10'd0, 9'h000, 0, 3'b000, 8'h00, 0, 0, 1));

    repeat (2) @(posedge Clk);
    #1;

    // Directed vector table.
    foreach (vecs[k]) begin
      step(vecs[k].rst, vecs[k].fl, vecs[k].st, vecs[k].fv, vecs[k].pc, vecs[k].inst);
      chk($sformatf("vec%0d_pc", k), IdPC, vecs[k].e_pc);
      chk($sformatf("vec%0d_inst", k), IdInst, vecs[k].e_inst);
      chk($sformatf("vec%0d_valid", k), IdValid, vecs[k].e_valid);
      chk($sformatf("vec%0d_branch", k), {BranchEZ, BranchNZ, BranchAlways}, vecs[k].e_br);
      chk($sformatf("vec%0d_target", k), Target, vecs[k].e_tgt);
      chk($sformatf("vec%0d_done", k), Done, vecs[k].e_done);
      chk($sformatf("vec%0d_inst_cnt", k), InstCount, vecs[k].e_ic);
      chk($sformatf("vec%0d_cycle_cnt", k), CycleCount, vecs[k].e_cc);
    end

    // Saturation: narrow instance preloaded to all-ones-minus-one, then 3 more loads.
    step(1, 0, 0, 0, 10'd0, 9'h000);
    for (int i = 0; i < 14; i++) step(0, 0, 0, 1, 10'(i), 9'h021);
    chk("sat_inst_pre", sInstCount, 4'hE);
    chk("sat_cycle_pre", sCycleCount, 4'hE);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1, 10'(20 + i), 9'h021);
      chk($sformatf("sat_inst_%0d", i), sInstCount, 4'hF);
      chk($sformatf("sat_cycle_%0d", i), sCycleCount, 4'hF);
    end
    chk("sat_wide_inst", InstCount, 16'd17);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      bit rst, fl, st, fv;
      logic [8:0] inst;
      int r;
      rst = ($urandom_range(0, 39) == 0);
      fl  = ($urandom_range(0, 7) == 0);
      st  = ($urandom_range(0, 4) == 0);
      fv  = ($urandom_range(0, 3) != 0);
      r   = $urandom_range(0, 15);
      inst = 9'($urandom);
      if (r < 3) inst[8:5] = 4'hC + 4'(r);
      else if (r == 3) inst[8:5] = 4'hF;
      step(rst, fl, st, fv, 10'($urandom), inst);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
